// File: rtl/lab3_button_irq_ctrl.sv
// -----------------------------------------------------------------------------
// lab3_button_irq_ctrl
//
// Interrupt-driven push-button handler that talks to a standard PIO core over
// a simple zero-wait-state register bus. On an enabled button interrupt it
// clears the PIO edge-capture register, waits out the contact bounce, clears
// the edge capture again to drop bounce-induced edges, reads the button level
// and counts the press when that level matches PRESS_LEVEL.
//
// After every reset the PIO irq mask is (re)written to 1 on the very first
// clock edge, so a PIO that was reset along with this block re-arms itself.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles spent waiting between the two edge-capture clears
//                    (>= 1; 50000 = 1 ms at 50 MHz)
//   PRESS_LEVEL      sampled button level that confirms a press
//   CNT_WIDTH        width of press_count (wraps modulo 2**CNT_WIDTH)
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   allow new button events to start a sequence
//   irq           in   interrupt from the button PIO
//   m_address     out  PIO register select (0 data, 2 irq mask, 3 edge capture)
//   m_chipselect  out  PIO access strobe, one cycle per access
//   m_write_n     out  active-low write strobe (1 whenever m_chipselect is 0)
//   m_writedata   out  PIO write data (non-zero only for the irq-mask write)
//   m_readdata    in   PIO read data, registered by the PIO
//   press_count   out  number of confirmed presses
//   press_pulse   out  one-cycle strobe per confirmed press
//   busy          out  high while a sequence (or the reset-time init) runs
// -----------------------------------------------------------------------------
module lab3_button_irq_ctrl #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic PRESS_LEVEL     = 1'b1,
  parameter int   CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 irq,
  output logic [1:0]           m_address,
  output logic                 m_chipselect,
  output logic                 m_write_n,
  output logic [31:0]          m_writedata,
  input  logic [31:0]          m_readdata,
  output logic [CNT_WIDTH-1:0] press_count,
  output logic                 press_pulse,
  output logic                 busy
);

  // Counter only has to hold DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CLEAR1,
    DEBOUNCE,
    CLEAR2,
    ADDR,
    SAMPLE
  } state_t;

  state_t          state;
  logic [DB_W-1:0] db_count;

  // Only bit 0 of the PIO data register carries the button.
  logic unused_readdata;
  assign unused_readdata = ^m_readdata[31:1];

  // All outputs are registered together with the state. Each transition
  // loads the bus outputs belonging to the state being entered, so a bus
  // access is visible during exactly the cycle its state is active. INIT is
  // the one exception: it is the reset state, so its mask write is launched
  // by the first edge after reset and is visible while the FSM already sits
  // in IDLE; busy stays high for that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register here, counter included, is cleared by the
    // asynchronous reset so an interrupted sequence leaves no trace.
    if (!reset_n) begin
      state        <= INIT;
      db_count     <= '0;
      press_count  <= '0;
      press_pulse  <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= ADDR_DATA;
      m_writedata  <= '0;
      busy         <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below are
      // overridden by the later assignments in the case arms, giving an idle
      // bus and no pulse unless a state asks otherwise.
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= ADDR_DATA;
      m_writedata  <= '0;
      press_pulse  <= 1'b0;
      busy         <= 1'b1;

      case (state)
        INIT: begin
          // Enable the button interrupt in the PIO.
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= ADDR_IRQ_MASK;
          m_writedata  <= 32'd1;
          state        <= IDLE;
        end

        IDLE: begin
          if (irq && enable) begin
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_address    <= ADDR_EDGE_CAP;
            state        <= CLEAR1;
          end else begin
            busy <= 1'b0;
          end
        end

        CLEAR1: begin
          db_count <= DB_LOAD;
          state    <= DEBOUNCE;
        end

        DEBOUNCE: begin
          // Counter reaching zero ends the wait: DEBOUNCE lasts exactly
          // DEBOUNCE_CYCLES cycles. Edges captured meanwhile are bounce and
          // are thrown away by the second clear.
          if (db_count == '0) begin
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_address    <= ADDR_EDGE_CAP;
            state        <= CLEAR2;
          end else begin
            db_count <= db_count - 1'b1;
          end
        end

        CLEAR2: begin
          // Read of the data register; the PIO registers the answer, which
          // is then available while the FSM is in SAMPLE.
          m_chipselect <= 1'b1;
          m_address    <= ADDR_DATA;
          state        <= ADDR;
        end

        ADDR: begin
          state <= SAMPLE;
        end

        SAMPLE: begin
          if (m_readdata[0] == PRESS_LEVEL) begin
            press_count <= press_count + 1'b1;
            press_pulse <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/lab3_button_irq_ctrl.md
LAB3_BUTTON_IRQ_CTRL -- requirements
Module: lab3_button_irq_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning wait cycles between edge-capture clear and level sample (1 ms at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter PRESS_LEVEL, default 1'b1, meaning the sampled in_port level that confirms a press.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning the width of press_count.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  when high, the controller accepts new button events.
REQ-007 irq  input  1  interrupt from the button PIO.
REQ-008 m_address  output  2  PIO register select: 0 = data, 2 = irq mask, 3 = edge capture.
REQ-009 m_chipselect  output  1  PIO access strobe.
REQ-010 m_write_n  output  1  active-low write strobe.
REQ-011 m_writedata  output  32  PIO write data.
REQ-012 m_readdata  input  32  PIO read data; registered by the PIO, valid one cycle after m_address is driven.
REQ-013 press_count  output  CNT_WIDTH  number of confirmed presses.
REQ-014 press_pulse  output  1  one-cycle strobe per confirmed press.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the states INIT, IDLE, CLEAR1, DEBOUNCE, CLEAR2, ADDR, SAMPLE.
REQ-017 INIT: one cycle, drive m_chipselect=1, m_write_n=0, m_address=2, m_writedata=1, then go to IDLE.
REQ-018 IDLE: m_chipselect=0, m_write_n=1, m_address=0; if irq && enable, go to CLEAR1 next cycle; otherwise stay in IDLE.
REQ-019 CLEAR1: one cycle, write m_address=3 with m_writedata=0; load the debounce counter with DEBOUNCE_CYCLES-1; go to DEBOUNCE.
REQ-020 DEBOUNCE: decrement the counter each cycle with no bus access; go to CLEAR2 in the cycle the counter equals 0, giving exactly DEBOUNCE_CYCLES cycles in DEBOUNCE.
REQ-021 CLEAR2: one cycle, write m_address=3 with m_writedata=0, discarding edge captures caused by bounce; go to ADDR.
REQ-022 ADDR: one cycle, m_chipselect=1, m_write_n=1, m_address=0; go to SAMPLE.
REQ-023 SAMPLE: evaluate m_readdata[0]; if it equals PRESS_LEVEL, increment press_count and assert press_pulse in the cycle after SAMPLE; always return to IDLE.
REQ-024 press_count SHALL wrap modulo 2^CNT_WIDTH (all-ones + 1 -> 0).
REQ-025 irq toggling while busy SHALL be ignored; irq still high on return to IDLE starts a new sequence.
REQ-026 enable going low mid-sequence SHALL NOT abort the sequence; it only blocks the IDLE -> CLEAR1 transition.
REQ-027 m_writedata SHALL be 0 in every state except INIT.
REQ-028 m_write_n SHALL be 1 whenever m_chipselect is 0.
REQ-029 Every bus access SHALL last exactly one cycle; the PIO has zero wait states.
REQ-030 busy, m_* and state outputs SHALL be registered, with no combinational path from irq to bus outputs.

Reset
REQ-031 While reset_n=0: state=INIT, press_count=0, press_pulse=0, debounce counter=0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=1.
REQ-032 Reset asserted in any state SHALL abandon the sequence; no press is counted for an interrupted sequence.
REQ-033 After reset_n rises, INIT SHALL execute in the first clock edge, so the irq mask is rewritten after every reset.

Verification (bench uses DEBOUNCE_CYCLES=4, PIO model attached)
REQ-034 Release reset -> exactly one write of 1 to address 2 in cycle 1; busy falls in cycle 2; press_count=0.
REQ-035 enable=1, in_port 0->1 held high -> write addr3 (CLEAR1), 4 idle cycles, write addr3 (CLEAR2), read addr0; press_pulse for 1 cycle; press_count=1; irq=0 afterwards.
REQ-036 in_port pulses high for 2 cycles during DEBOUNCE, then stays low -> CLEAR2 clears capture; sample reads 0; press_count unchanged; no press_pulse.
REQ-037 enable=0 with irq=1 -> stays in IDLE, no bus activity; enable->1 -> sequence starts in the next cycle.
REQ-038 press_count preloaded to 16'hFFFF via 65535 presses (or force), one more press -> press_count=16'h0000, press_pulse=1.
REQ-039 reset_n pulsed low during DEBOUNCE -> outputs take their REQ-031 values immediately; INIT repeats; press_count=0.
